fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
- Sequencer for the 3-tap FIR datapath: owns the tap delay line and coefficient registers, and time-shares one signed DATAWIDTH x DATAWIDTH multiplier across the three taps.
- Sits between the sample source (valid/ready) and the result sink; run control uses the same start/stop/done semantics as TOP_FIR.
- Coefficients are writable only while idle.

Parameters:
- DATAWIDTH, 16, width of samples and coefficients (signed, Q8 fractional).
- PRODUCT_WIDTH, 2*DATAWIDTH, width of y (signed, Q16).
- C0_INIT, 16'sh0040, reset value of coefficient 0 (0.25).
- C1_INIT, 16'sh0080, reset value of coefficient 1 (0.5).
- C2_INIT, 16'sh0040, reset value of coefficient 2 (0.25).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level; sampled in IDLE only.
- stop  in  1  level; request to end the run.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  2  coefficient index 0..2; 3 is ignored.
- cfg_data  in  DATAWIDTH  coefficient value (signed).
- x  in  DATAWIDTH  input sample (signed).
- x_valid  in  1  x is valid.
- x_ready  out  1  block accepts x this cycle.
- y  out  PRODUCT_WIDTH  filtered output (signed, saturated).
- y_valid  out  1  one-cycle pulse; y is new.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a run ends.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; delay line d0..d2 = 0; accumulator = 0.
  - Coefficients c0..c2 = C0_INIT..C2_INIT.
  - y = 0; y_valid, done, ovf, x_ready, busy and stop_pend all = 0.
  - Reset mid-run aborts immediately; no done and no y_valid are produced.
- States: IDLE, WAIT, MAC0, MAC1, MAC2.
- IDLE:
  - cfg_we with cfg_addr 0..2 writes c[cfg_addr] at the clock edge.
  - start=1 and stop=0: go to WAIT; clear d0..d2 and ovf.
  - start=1 and stop=1 in the same cycle: stop wins; stay in IDLE, no done.
- cfg_we in any state other than IDLE is ignored.
- WAIT:
  - x_ready = 1; x_ready is 0 in every other state.
  - stop=1 has priority over a sample: go to IDLE and pulse done the next cycle. No sample is accepted, even if x_valid=1.
  - Otherwise x_valid=1 is the handshake: shift d2<=d1, d1<=d0, d0<=x, then go to MAC0.
- MAC0: acc <= c0*d0 (sign-extended to PRODUCT_WIDTH+2).
- MAC1: acc <= acc + c1*d1.
- MAC2:
  - Compute s = acc + c2*d2.
  - y <= s saturated to signed PRODUCT_WIDTH (max 0x7FFF_FFFF, min 0x8000_0000).
  - ovf <= ovf | (saturation occurred); y_valid pulses the next cycle.
  - Next state is WAIT, or IDLE if stop_pend=1 (done pulses together with y_valid; stop_pend clears).
- stop seen during MAC0, MAC1 or MAC2 sets stop_pend; the sample in flight always completes.
- start while busy is ignored.
- Timing: the handshake in cycle T gives y_valid in cycle T+4. Maximum throughput is one sample per 4 cycles.
- y holds its value between pulses and is not cleared by stop or start.
- Only one product is formed per cycle (a single multiplier instance).

Test Plan:
- Reset defaults: rst=0 then 1 -> y=0, y_valid=0, busy=0, ovf=0, x_ready=0.
- Step response at 0.5: start, then x=0x0080 on four handshakes -> y = 8192, 24576, 32768, 32768. Each y_valid arrives exactly 4 cycles after its handshake.
- Coefficient write and restart:
  - In IDLE, write c0=c1=c2=0x0100; start; x=0x0066 four times -> y = 26112, 52224, 78336, 78336.
  - A cfg_we issued while busy leaves the coefficients unchanged.
- Stop timing:
  - stop asserted in MAC1 -> y_valid and done pulse in the same cycle; then IDLE and busy=0.
  - stop in WAIT with x_valid=1 -> no handshake; done 1 cycle later.
- Saturation: c0..c2=0x8000, x=0x8000 -> y = 0x4000_0000, then 0x7FFF_FFFF; ovf=1 and stays 1 until the next start from IDLE.
- Reset mid-run: drive rst=0 during MAC1 -> IDLE immediately, no y_valid or done; coefficients return to C0_INIT..C2_INIT.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - 3-tap FIR sequencer sharing one signed multiplier across taps
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start, stop        run control (start sampled in IDLE only; stop ends the run)
//   cfg_we/addr/data   coefficient write, honoured only while idle (addr 3 ignored)
//   x, x_valid, x_ready  sample input handshake (x_ready high only in WAIT)
//   y, y_valid         saturated Q16 result and its one-cycle strobe
//   busy, done, ovf    not-idle status, end-of-run pulse, sticky saturation flag
module fir_seq_ctrl #(
   parameter int DATAWIDTH     = 16,
   parameter int PRODUCT_WIDTH = 2*DATAWIDTH,
   parameter logic signed [DATAWIDTH-1:0] C0_INIT = 16'sh0040,
   parameter logic signed [DATAWIDTH-1:0] C1_INIT = 16'sh0080,
   parameter logic signed [DATAWIDTH-1:0] C2_INIT = 16'sh0040
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            stop,
   input  logic                            cfg_we,
   input  logic [1:0]                      cfg_addr,
   input  logic signed [DATAWIDTH-1:0]     cfg_data,
   input  logic signed [DATAWIDTH-1:0]     x,
   input  logic                            x_valid,
   output logic                            x_ready,
   output logic signed [PRODUCT_WIDTH-1:0] y,
   output logic                            y_valid,
   output logic                            busy,
   output logic                            done,
   output logic                            ovf
);

   // Two guard bits cover the sum of three full-scale products.
   localparam int ACCW = PRODUCT_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_MAC0,
      S_MAC1,
      S_MAC2
   } state_t;

   state_t state;

   logic signed [DATAWIDTH-1:0]     c0, c1, c2;
   logic signed [DATAWIDTH-1:0]     d0, d1, d2;
   logic signed [ACCW-1:0]          acc;
   logic                            stop_pend;

   logic signed [DATAWIDTH-1:0]     mul_a, mul_b;
   logic signed [2*DATAWIDTH-1:0]   prod;
   logic signed [ACCW-1:0]          prod_ext;
   logic signed [ACCW-1:0]          sum;
   logic                            sat_hit;
   logic signed [PRODUCT_WIDTH-1:0] sat_val;

   // Operand select for the single multiplier: the tap index follows the MAC state.
   always_comb begin
      mul_a = c0;
      mul_b = d0;
      case (state)
         S_MAC1: begin
            mul_a = c1;
            mul_b = d1;
         end
         S_MAC2: begin
            mul_a = c2;
            mul_b = d2;
         end
         default: begin
            mul_a = c0;
            mul_b = d0;
         end
      endcase
   end

   assign prod     = (2*DATAWIDTH)'(mul_a) * (2*DATAWIDTH)'(mul_b);
   assign prod_ext = ACCW'(prod);
   assign sum      = acc + prod_ext;

   // Saturation: the bits above the result's sign bit must all equal the sign.
   always_comb begin
      sat_hit = (sum[ACCW-1:PRODUCT_WIDTH-1] != {(ACCW-PRODUCT_WIDTH+1){1'b0}}) &&
                (sum[ACCW-1:PRODUCT_WIDTH-1] != {(ACCW-PRODUCT_WIDTH+1){1'b1}});
      sat_val = sum[PRODUCT_WIDTH-1:0];
      if (sat_hit) begin
         sat_val = sum[ACCW-1] ? {1'b1, {(PRODUCT_WIDTH-1){1'b0}}}
                               : {1'b0, {(PRODUCT_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         c0        <= C0_INIT;
         c1        <= C1_INIT;
         c2        <= C2_INIT;
         d0        <= '0;
         d1        <= '0;
         d2        <= '0;
         acc       <= '0;
         stop_pend <= 1'b0;
         y         <= '0;
         y_valid   <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         x_ready   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_we) begin
                  case (cfg_addr)
                     2'd0:    c0 <= cfg_data;
                     2'd1:    c1 <= cfg_data;
                     2'd2:    c2 <= cfg_data;
                     default: ;
                  endcase
               end
               // A simultaneous stop cancels the start.
               if (start && !stop) begin
                  state     <= S_WAIT;
                  d0        <= '0;
                  d1        <= '0;
                  d2        <= '0;
                  ovf       <= 1'b0;
                  stop_pend <= 1'b0;
                  busy      <= 1'b1;
                  x_ready   <= 1'b1;
               end
            end
            S_WAIT: begin
               if (stop) begin
                  state   <= S_IDLE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  x_ready <= 1'b0;
               end else if (x_valid) begin
                  d2      <= d1;
                  d1      <= d0;
                  d0      <= x;
                  state   <= S_MAC0;
                  x_ready <= 1'b0;
               end
            end
            S_MAC0: begin
               acc       <= prod_ext;
               stop_pend <= stop_pend | stop;
               state     <= S_MAC1;
            end
            S_MAC1: begin
               acc       <= sum;
               stop_pend <= stop_pend | stop;
               state     <= S_MAC2;
            end
            S_MAC2: begin
               y       <= sat_val;
               y_valid <= 1'b1;
               ovf     <= ovf | sat_hit;
               // A stop arriving in this last cycle still ends the run here.
               if (stop_pend || stop) begin
                  state     <= S_IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  stop_pend <= 1'b0;
               end else begin
                  state   <= S_WAIT;
                  x_ready <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               x_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

   logic               clk;
   logic               rst;
   logic               start;
   logic               stop;
   logic               cfg_we;
   logic [1:0]         cfg_addr;
   logic signed [15:0] cfg_data;
   logic signed [15:0] x;
   logic               x_valid;
   logic               x_ready;
   logic signed [31:0] y;
   logic               y_valid;
   logic               busy;
   logic               done;
   logic               ovf;

   fir_seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .x        (x),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .y        (y),
      .y_valid  (y_valid),
      .busy     (busy),
      .done     (done),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] xin;
      logic [31:0] yexp;
   } vec_t;

   typedef struct {
      logic [31:0] yexp;
      int          hs_cyc;
   } sb_t;

   vec_t        tbl [15];
   sb_t         sb [$];
   sb_t         e;
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          done_snap;
   logic [31:0] cur_y;
   bit          arm = 0;
   bit          hs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: sample outputs on the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (rst && y_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_y_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("y", y, e.yexp);
            chk("latency", 32'(cyc - e.hs_cyc), 32'd4);
         end
      end
      if (rst && done) done_cnt++;
      if (arm && x_valid && x_ready && !stop) begin
         sb.push_back('{cur_y, cyc});
         arm = 0;
         hs  = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] v, input logic [31:0] ey);
      x       = v;
      x_valid = 1'b1;
      cur_y   = ey;
      arm     = 1;
      hs      = 0;
      for (int i = 0; i < 20 && !hs; i++) tick();
      chk("handshake", 32'(hs), 32'd1);
      x_valid = 1'b0;
      arm     = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic write_coef(input logic [1:0] a, input logic [15:0] v);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = v;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // step at 0.5 with default taps 0.25/0.5/0.25
      tbl[0]  = '{16'h0080, 32'd8192};
      tbl[1]  = '{16'h0080, 32'd24576};
      tbl[2]  = '{16'h0080, 32'd32768};
      tbl[3]  = '{16'h0080, 32'd32768};
      // unity taps, x = 0x66
      tbl[4]  = '{16'h0066, 32'd26112};
      tbl[5]  = '{16'h0066, 32'd52224};
      tbl[6]  = '{16'h0066, 32'd78336};
      tbl[7]  = '{16'h0066, 32'd78336};
      // taps all -1.0: positive overflow then recovery
      tbl[8]  = '{16'h8000, 32'h4000_0000};
      tbl[9]  = '{16'h8000, 32'h7FFF_FFFF};
      tbl[10] = '{16'h0000, 32'h7FFF_FFFF};
      tbl[11] = '{16'h0000, 32'h4000_0000};
      // defaults restored by reset
      tbl[12] = '{16'h0080, 32'd8192};
      tbl[13] = '{16'h0080, 32'd24576};
      tbl[14] = '{16'h0080, 32'd32768};

      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
      cfg_addr = 2'd0; cfg_data = 16'sd0; x = 16'sd0; x_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      chk("rst_y", y, 32'd0);
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_x_ready", 32'(x_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);
      tick();
      chk("startstop_no_done", 32'(done_cnt), 32'd0);

      // step response
      do_start();
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_x_ready", 32'(x_ready), 32'd1);
      for (int i = 0; i < 4; i++) send(tbl[i].xin, tbl[i].yexp);
      drain();
      chk("step_ovf", 32'(ovf), 32'd0);

      // stop in WAIT beats a valid sample
      done_snap = done_cnt;
      stop = 1'b1; x_valid = 1'b1; x = 16'sh1234;
      tick();
      chk("waitstop_done", 32'(done), 32'd1);
      chk("waitstop_busy", 32'(busy), 32'd0);
      chk("waitstop_x_ready", 32'(x_ready), 32'd0);
      stop = 1'b0; x_valid = 1'b0;
      tick();
      chk("waitstop_done_pulse", 32'(done), 32'd0);
      chk("waitstop_done_cnt", 32'(done_cnt - done_snap), 32'd1);
      chk("y_hold", y, 32'd32768);

      // unity coefficients; addr 3 and busy writes must be ignored
      write_coef(2'd0, 16'h0100);
      write_coef(2'd1, 16'h0100);
      write_coef(2'd2, 16'h0100);
      write_coef(2'd3, 16'h7FFF);
      do_start();
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 16'sh7FFF;
      for (int i = 4; i < 8; i++) send(tbl[i].xin, tbl[i].yexp);
      drain();
      cfg_we = 1'b0;

      // stop raised during MAC1: result and done in the same cycle
      send(16'h0066, 32'd78336);
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("mac1stop_y_valid", 32'(y_valid), 32'd1);
      chk("mac1stop_done", 32'(done), 32'd1);
      tick();
      chk("mac1stop_busy", 32'(busy), 32'd0);
      chk("mac1stop_x_ready", 32'(x_ready), 32'd0);
      chk("mac1stop_drain", 32'(sb.size()), 32'd0);

      // saturation and sticky ovf
      write_coef(2'd0, 16'h8000);
      write_coef(2'd1, 16'h8000);
      write_coef(2'd2, 16'h8000);
      do_start();
      for (int i = 8; i < 12; i++) send(tbl[i].xin, tbl[i].yexp);
      drain();
      chk("sat_ovf", 32'(ovf), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("sat_ovf_after_stop", 32'(ovf), 32'd1);
      do_start();
      chk("sat_ovf_cleared", 32'(ovf), 32'd0);

      // reset during MAC1 aborts without y_valid or done
      send(16'h0080, 32'd0);
      tick();
      done_snap = done_cnt;
      rst = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_y_valid", 32'(y_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_y", y, 32'd0);
      sb.delete();
      tick();
      rst = 1'b1;
      repeat (6) tick();
      chk("abort_no_done", 32'(done_cnt - done_snap), 32'd0);
      do_start();
      for (int i = 12; i < 15; i++) send(tbl[i].xin, tbl[i].yexp);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
